// File: rtl/uart_pkg.sv
// Shared types and parameter-legality helpers for the UART receive path.
// Latency: none (types and functions only).
// Backpressure: none. Macros: UART_RX_PARITY_EN (parity state and flag), UART_RX_DATA_BITS (entry data width, default 8).
`ifndef UART_RX_DATA_BITS
`define UART_RX_DATA_BITS 8
`endif

package uart_pkg;

  // Width of the data field carried in each queue entry.
  localparam int UART_RX_DW = `UART_RX_DATA_BITS;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  typedef struct packed {
    logic [UART_RX_DW-1:0] data;
    logic                  frame_err;
`ifdef UART_RX_PARITY_EN
    logic                  parity_err;
`endif
  } uart_rx_entry_t;

  function automatic bit uart_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // The data width must also match the entry width fixed by UART_RX_DATA_BITS.
  function automatic bit uart_rx_params_ok(input int cpb, input int db, input int sb,
                                           input int po, input int depth, input int entry_dw);
    return (cpb >= 4) && (db >= 5) && (db <= 9) && (db == entry_dw) &&
           ((sb == 1) || (sb == 2)) && ((po == 0) || (po == 1)) &&
           (depth >= 2) && uart_is_pow2(depth);
  endfunction

endpackage

// File: rtl/uart_rx_queue.sv
// Generic show-ahead FIFO; head entry is visible combinationally whenever non-empty.
// Latency: a push is visible on the edge after it is written; a pop exposes the next entry on the next edge.
// Backpressure: a push while full is accepted only with a simultaneous pop; otherwise it is ignored.
module uart_rx_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_vld,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_empty;
  logic             w_full;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_en = i_pop && !w_empty;
  assign w_wr_en = i_push && (!w_full || w_rd_en);

  assign o_vld  = !w_empty;
  assign o_full = w_full;
  assign o_dat  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Advance read/write pointers on accepted pops and pushes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_top.sv
// UART receiver (oversampled, LSB first, 1-2 stop bits) feeding a show-ahead queue of words with error flags.
// Latency: word visible one edge after the final stop-bit sample; ser_in reaches the FSM through 2 sync flops.
// Backpressure: consumer pops with rx_valid && rx_ready; a word arriving at a full queue is dropped and sets overrun.
// Macro UART_RX_PARITY_EN adds a checked parity bit after the data.
module uart_rx_fifo_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 416,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 masterclk,
  input  logic                 reset_n,
  input  logic                 ser_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  if (!uart_rx_params_ok(CLKS_PER_BIT, DATA_BITS, STOP_BITS, PARITY_ODD, FIFO_DEPTH, UART_RX_DW))
  begin : g_bad_params
    $error("uart_rx_fifo_top: illegal parameter set");
  end

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam int               ENTRY_W   = $bits(uart_rx_entry_t);

  logic                 r_sync1;
  logic                 r_rxs;
  uart_rx_state_t       r_state,   w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,     w_cnt_nxt;
  logic [3:0]           r_bitcnt,  w_bitcnt_nxt;
  logic                 r_stopcnt, w_stopcnt_nxt;
  logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
  logic                 r_ferr,    w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr,    w_perr_nxt;
`endif
  logic                 r_overrun;
  logic                 w_tick;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_q_full;
  uart_rx_entry_t       w_entry;
  uart_rx_entry_t       w_head;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge masterclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= ser_in;
      r_rxs   <= r_sync1;
    end
  end

  assign w_tick = (r_cnt == '0);

  // Deserialiser state and datapath registers.
  always_ff @(posedge masterclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_shift   <= '0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_stopcnt <= w_stopcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ferr    <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_perr    <= w_perr_nxt;
`endif
    end
  end

  // Next-state logic: every sample is taken when the baud counter expires.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_tick ? r_cnt : r_cnt - CNT_W'(1);
    w_bitcnt_nxt  = r_bitcnt;
    w_stopcnt_nxt = r_stopcnt;
    w_shift_nxt   = r_shift;
    w_ferr_nxt    = r_ferr;
`ifdef UART_RX_PARITY_EN
    w_perr_nxt    = r_perr;
`endif
    w_push        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (!r_rxs) begin
          w_cnt_nxt     = CNT_HALF;
          w_bitcnt_nxt  = '0;
          w_stopcnt_nxt = 1'b0;
          w_ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
          w_perr_nxt    = 1'b0;
`endif
          w_state_nxt   = ST_START;
        end
      end
      ST_START: if (w_tick) begin
        if (r_rxs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = CNT_FULL;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: if (w_tick) begin
        w_shift_nxt = {r_rxs, r_shift[DATA_BITS-1:1]};
        w_cnt_nxt   = CNT_FULL;
        if (r_bitcnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end else begin
          w_bitcnt_nxt = r_bitcnt + 4'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (w_tick) begin
        w_perr_nxt  = ((^r_shift) ^ r_rxs) != (PARITY_ODD != 0);
        w_cnt_nxt   = CNT_FULL;
        w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: if (w_tick) begin
        if (!r_rxs) w_ferr_nxt = 1'b1;
        if (r_stopcnt == STOP_LAST) begin
          w_push      = 1'b1;
          w_state_nxt = r_rxs ? ST_IDLE : ST_WAIT_HIGH;
        end else begin
          w_stopcnt_nxt = r_stopcnt + 1'b1;
          w_cnt_nxt     = CNT_FULL;
        end
      end
      ST_WAIT_HIGH: if (r_rxs) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Entry written on the final stop sample; that sample's own result is folded in directly.
  always_comb begin
    w_entry           = '0;
    w_entry.data      = UART_RX_DW'(r_shift);
    w_entry.frame_err = r_ferr | ~r_rxs;
`ifdef UART_RX_PARITY_EN
    w_entry.parity_err = r_perr;
`endif
  end

  assign w_pop = rx_valid && rx_ready;

  uart_rx_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .i_clk      (masterclk),
    .i_rst_n    (reset_n),
    .i_push     (w_push),
    .i_push_dat (w_entry),
    .i_pop      (w_pop),
    .o_dat      (w_head),
    .o_vld      (rx_valid),
    .o_full     (w_q_full)
  );

  // Sticky overrun: a dropped word sets it, and a set beats a clear in the same cycle.
  always_ff @(posedge masterclk or negedge reset_n) begin
    if (!reset_n)                         r_overrun <= 1'b0;
    else if (w_push && w_q_full && !w_pop) r_overrun <= 1'b1;
    else if (overrun_clr)                 r_overrun <= 1'b0;
  end

  assign overrun      = r_overrun;
  assign rx_data      = DATA_BITS'(w_head.data);
  assign rx_frame_err = w_head.frame_err;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = w_head.parity_err;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_top.sv
// Directed bench for uart_rx_fifo_top with a queue-based reference model checked every cycle.
// Latency: model pushes each frame on the edge of its final stop-bit sample, counted from the start-bit fall.
// Backpressure: model pops on rx_ready with a non-empty queue and drops words arriving at a full queue.
module tb_uart_rx_fifo_top;

  localparam int CPB   = 416;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int PO    = 0;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NP = 1;
`else
  localparam int NP = 0;
`endif
  localparam int FRAME = (1 + DB + NP + SB) * CPB;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  typedef struct packed {
    logic [31:0] due;
    exp_t        e;
  } pend_t;

  logic         clk;
  logic         reset_n;
  logic         ser_in;
  logic [DB-1:0] rx_data;
  logic         rx_frame_err;
  logic         rx_parity_err;
  logic         rx_valid;
  logic         rx_ready;
  logic         overrun;
  logic         overrun_clr;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  bit    run_cmp = 0;
  exp_t  mq[$];
  pend_t pend[$];
  bit    m_ovr = 0;

  uart_rx_fifo_top #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .PARITY_ODD   (PO),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .masterclk     (clk),
    .reset_n       (reset_n),
    .ser_in        (ser_in),
    .rx_data       (rx_data),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain queue of expected words, timed from the frame arithmetic.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      pend.delete();
      m_ovr = 0;
    end else begin
      bit    do_pop;
      bit    was_full;
      bit    set_ovr;
      pend_t p;
      cyc++;
      do_pop   = rx_ready && (mq.size() > 0);
      was_full = (mq.size() == DEPTH);
      set_ovr  = 0;
      if (do_pop) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        if (was_full && !do_pop) set_ovr = 1;
        else mq.push_back(p.e);
      end
      if (set_ovr) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (run_cmp && reset_n) begin
      check("cmp_valid", rx_valid, mq.size() > 0);
      check("cmp_overrun", overrun, m_ovr);
      if (mq.size() > 0) begin
        check("cmp_data", rx_data, mq[0].data);
        check("cmp_ferr", rx_frame_err, mq[0].ferr);
        check("cmp_perr", rx_parity_err, mq[0].perr);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ (PO != 0);
  endfunction

  // Called at a negedge; drives one whole frame and leaves the line at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopv);
    pend_t p;
    p.e.data = d;
    p.e.ferr = !stopv;
    p.e.perr = (NP != 0) ? (((^d) ^ pbit) != (PO != 0)) : 1'b0;
    p.due    = 32'(cyc + 3 + CPB/2 + (DB + NP + SB) * CPB);
    pend.push_back(p);
    ser_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < DB; i++) begin
      ser_in = d[i];
      idle(CPB);
    end
    if (NP != 0) begin
      ser_in = pbit;
      idle(CPB);
    end
    for (int i = 0; i < SB; i++) begin
      ser_in = stopv;
      idle(CPB);
    end
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d55;
    reset_n     = 1'b0;
    ser_in      = 1'b1;
    rx_ready    = 1'b0;
    overrun_clr = 1'b0;
    idle(4);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_perr", rx_parity_err, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    run_cmp = 1;
    idle(4);

    // Single clean frame
    send_frame(8'hA5, good_par(8'hA5), 1'b1);
    idle(4);
    check("single_valid", rx_valid, 1);
    check("single_data", rx_data, 8'hA5);
    check("single_ferr", rx_frame_err, 0);
    check("single_perr", rx_parity_err, 0);
    pulse_ready();
    check("single_popped", rx_valid, 0);

    // 100-cycle glitch is rejected at the start-bit centre
    ser_in = 1'b0;
    idle(100);
    ser_in = 1'b1;
    idle(2 * CPB);
    check("glitch_valid", rx_valid, 0);

    // Low stop bit followed by a long break yields one entry
    send_frame(8'h3C, good_par(8'h3C), 1'b0);
    idle(3 * FRAME);
    ser_in = 1'b1;
    idle(CPB);
    check("break_valid", rx_valid, 1);
    check("break_data", rx_data, 8'h3C);
    check("break_ferr", rx_frame_err, 1);
    pulse_ready();
    check("break_one_entry", rx_valid, 0);

    // Five back-to-back words into a four-entry queue
    for (int k = 1; k <= 5; k++) send_frame(8'(k), good_par(8'(k)), 1'b1);
    idle(4);
    check("ovr_set", overrun, 1);
    for (int k = 1; k <= 4; k++) begin
      check("ovr_pop_data", rx_data, k);
      pulse_ready();
    end
    check("ovr_drained", rx_valid, 0);
    check("ovr_sticky", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_cleared", overrun, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity needs a 1
    send_frame(8'h07, 1'b0, 1'b1);
    idle(4);
    check("par_bad_flag", rx_parity_err, 1);
    pulse_ready();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check("par_good_flag", rx_parity_err, 0);
    check("par_good_data", rx_data, 8'h07);
    pulse_ready();
`endif

    // Reset in the middle of 0x55 with two words queued
    send_frame(8'h21, good_par(8'h21), 1'b1);
    send_frame(8'h22, good_par(8'h22), 1'b1);
    idle(4);
    check("rmid_queued", rx_valid, 1);
    d55 = 8'h55;
    ser_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      ser_in = d55[i];
      idle(CPB);
    end
    idle(CPB / 2);
    #2;
    reset_n = 1'b0;
    ser_in  = 1'b1;
    #1;
    check("rmid_valid", rx_valid, 0);
    check("rmid_overrun", overrun, 0);
    check("rmid_data", rx_data, 0);
    idle(5);
    reset_n = 1'b1;
    idle(8);
    send_frame(8'h12, good_par(8'h12), 1'b1);
    idle(4);
    check("after_rst_valid", rx_valid, 1);
    check("after_rst_data", rx_data, 8'h12);
    check("after_rst_ferr", rx_frame_err, 0);
    pulse_ready();
    idle(4);
    check("after_rst_empty", rx_valid, 0);

    run_cmp = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_top.md
# uart_rx_fifo_top

Parametrised UART receiver with a buffered output queue, successor to the fixed 8N1 serial path used by the z80test system. Oversamples `ser_in` at a compile-time `CLKS_PER_BIT`, deserialises `DATA_BITS`-wide frames with 1 or 2 stop bits, and queues each word with its error flags in a `FIFO_DEPTH`-entry show-ahead FIFO. The consumer reads through a valid/ready handshake; the CPU I/O decoder or a test harness sits on that side.

## Interface
- `CLKS_PER_BIT`, 416, master clocks per bit (4 MHz / 9600); must be at least 4.
- `DATA_BITS`, 8, data bits per frame; legal range 5–9.
- `STOP_BITS`, 1, stop bits checked; legal values 1 or 2.
- `PARITY_ODD`, 0, 1 selects odd parity and 0 selects even. Used only when `UART_RX_PARITY_EN` is defined.
- `FIFO_DEPTH`, 4, number of queue entries; must be a power of 2 and at least 2.

Ports (one clock; asynchronous active-low reset):
- `masterclk` input 1: the single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous active-low reset.
- `ser_in` input 1: serial line, idles high; asynchronous to `masterclk`.
- `rx_data` output `DATA_BITS`: head-of-queue word, LSB received first. Reset value 0.
- `rx_frame_err` output 1: the head word had a low stop bit. Reset value 0.
- `rx_parity_err` output 1: the head word failed the parity check. Always 0 without the macro. Reset value 0.
- `rx_valid` output 1: the queue is non-empty. Reset value 0.
- `rx_ready` input 1: the consumer accepts the head word.
- `overrun` output 1: sticky flag; a word was dropped because the queue was full. Reset value 0.
- `overrun_clr` input 1: clears `overrun`.

## Operation
- **Input synchroniser:** `ser_in` passes through a 2-flop synchroniser. Both flops reset to 1. The FSM uses only the synchronised signal `rxs`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - **IDLE:** on `rxs`=0, load the baud counter with `CLKS_PER_BIT/2 - 1` and go to START.
  - **START:** when the counter reaches 0, sample `rxs`.
    - `rxs`=1: glitch; return to IDLE.
    - `rxs`=0: reload the counter with `CLKS_PER_BIT-1` and go to DATA.
  - **DATA:** sample at each counter expiry, shift into the MSB side (LSB-first). After `DATA_BITS` samples, go to PARITY (macro defined) or STOP.
  - **PARITY:** one sample; compare against the computed parity.
  - **STOP:** take `STOP_BITS` samples at bit-centre. Frame error if any sample is 0.
    - After the final sample, push {data, frame_err, parity_err} in the same cycle.
    - Go to IDLE if the final sample is 1, otherwise to WAIT_HIGH.
  - **WAIT_HIGH:** remain until `rxs`=1, then go to IDLE. A break does not produce repeated frames.
- **Queue:** show-ahead; the outputs always reflect the head entry.
  - Pop when `rx_valid && rx_ready`.
  - Push while full without a simultaneous pop: drop the new word and set `overrun`. The stored contents are unchanged.
  - Push and pop in the same cycle while full: both occur and `overrun` does not set.
  - Push and pop in the same cycle while empty: impossible, because `rx_valid`=0.
  - Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits. The wrap bit distinguishes full from empty.
- **`overrun_clr`** asserted in the same cycle as a new overrun event leaves `overrun`=1 (set wins).
- **Reset:** asserting `reset_n` mid-frame abandons the frame and empties the queue. The FSM returns to IDLE and all outputs take their reset values.

## Timing
- A falling edge on `ser_in` reaches `rxs` 2 cycles later.
- Start is sampled `CLKS_PER_BIT/2` cycles after detection. Each subsequent sample follows the previous one by exactly `CLKS_PER_BIT` cycles.
- The push occurs on the cycle of the final stop sample. `rx_valid` and `rx_data` update on the following edge. There is no bypass path.
- After a pop, the next entry (or `rx_valid`=0) appears on the next edge.
- Back-to-back frames are supported: IDLE is entered at mid-stop, leaving half a bit of margin.

## Configuration
- **`UART_RX_PARITY_EN`**
  - Defined: the PARITY state exists. One parity bit follows the data and is checked per `PARITY_ODD`, and `rx_parity_err` is stored per entry.
  - Undefined: there is no PARITY state, the frame is start + data + stop, `rx_parity_err` is tied to 0, and queue entries exclude the parity bit.

## Structure
- **Package `uart_pkg`:** FSM state enum `uart_rx_state_t`, and entry struct `uart_rx_entry_t` parametrised via macro-sized width. It also holds parameter-legality helper functions.
- **Sub-module `uart_rx_queue`:** the generic show-ahead FIFO (width, depth). The top instantiates the deserialiser FSM inline plus one `uart_rx_queue`.

## Test plan
- **Single frame:** 8N1 with `CLKS_PER_BIT`=416; send 0xA5 and hold `rx_ready`=0 → `rx_valid`=1, `rx_data`=0xA5, both error flags 0. Assert `rx_ready` for 1 cycle → `rx_valid`=0.
- **Glitch rejection:** 100-cycle low pulse on `ser_in` → FSM returns to IDLE and `rx_valid` stays 0.
- **Framing error and break:** send 0x3C with the stop bit low, then hold the line low for 3 frames → exactly one entry appears, with `rx_frame_err`=1 and `rx_data`=0x3C.
- **Overrun:** `FIFO_DEPTH`=4 and `rx_ready`=0; send 0x01–0x05 back-to-back → `overrun`=1. Popping yields 0x01–0x04 only. Pulse `overrun_clr` → `overrun`=0.
- **Parity (macro defined):** `PARITY_ODD`=0; send 0x07 with a parity bit of 0 → `rx_parity_err`=1. Send 0x07 with a parity bit of 1 → `rx_parity_err`=0.
- **Reset mid-operation:** assert `reset_n`=0 during the DATA bits of 0x55 with 2 entries queued → `rx_valid`=0 and `overrun`=0 immediately. The next clean frame, 0x12, is received correctly.
